// File: rtl/packet_disassembler.sv
// Splits one wide message into a run of narrow chunks, most-significant chunk first.
// ostream_val stays high for the whole message and drops for at least one cycle between messages.
module packet_disassembler #(
  parameter  int nbits_in  = 64,
  parameter  int nbits_out = 32,
  localparam int nchunks   = (nbits_in + nbits_out - 1) / nbits_out,
  localparam int cnt_nbits = (nchunks > 1) ? $clog2(nchunks) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [nbits_in-1:0]  istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [nbits_out-1:0] ostream_msg,
  output logic                 ostream_last,
  output logic                 busy
);

  localparam int buf_nbits = nchunks * nbits_out;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [cnt_nbits-1:0] cnt, cnt_next;
  logic [buf_nbits-1:0] msg_buf, msg_buf_next;
  logic                 is_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      msg_buf <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      msg_buf <= msg_buf_next;
    end
  end

  // istream_rdy is only raised in IDLE, so the last chunk can never bypass into a new load.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    msg_buf_next = msg_buf;
    istream_rdy  = 1'b0;
    ostream_val  = 1'b0;
    ostream_last = 1'b0;
    busy         = 1'b0;
    is_last      = (cnt == cnt_nbits'(nchunks - 1));
    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          msg_buf_next = buf_nbits'(istream_msg);
          cnt_next     = '0;
          state_next   = SEND;
        end
      end
      SEND: begin
        ostream_val  = 1'b1;
        busy         = 1'b1;
        ostream_last = is_last;
        if (ostream_rdy) begin
          if (is_last) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + cnt_nbits'(1);
          end
        end
      end
    endcase
  end

  // Chunk 0 is the top slice of the zero-padded buffer, so any padding leads.
  always_comb begin
    ostream_msg = '0;
    for (int i = 0; i < nchunks; i++) begin
      if (cnt == cnt_nbits'(i)) begin
        ostream_msg = msg_buf[(nchunks-1-i)*nbits_out +: nbits_out];
      end
    end
  end

endmodule

// File: doc/packet_disassembler.md
Name: packet_disassembler

Overview:
- Splits one wide response message into a sequence of narrow chunks, each the width of the SPI data path.
- Sits directly upstream of the response arbiter. Each arbiter input is driven by one packet_disassembler instance.
- Holds ostream_val continuously high for every chunk of one message, so the arbiter keeps its grant for the whole message.
- Drops ostream_val for at least one cycle between messages, so the arbiter can re-arbitrate.

Parameters:
- nbits_in, 64, width of the incoming wide message; must be ≥ 1.
- nbits_out, 32, width of each outgoing chunk (SPI data width); must be ≥ 1.
- nchunks, ceil(nbits_in / nbits_out), number of chunks per message; derived, not overridden.
- cnt_nbits, max(1, $clog2(nchunks)), width of the chunk counter; derived.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- istream_val  input  1  wide message valid
- istream_rdy  output  1  block can accept a wide message
- istream_msg  input  nbits_in  wide message
- ostream_val  output  1  chunk valid (goes to arbiter istream_val[i])
- ostream_rdy  input  1  arbiter ready for this input
- ostream_msg  output  nbits_out  current chunk
- ostream_last  output  1  current chunk is the final chunk of the message
- busy  output  1  message held and not yet fully sent

Behaviour:
- States:
  - IDLE (encoding 0)
  - SEND (encoding 1)
- Registers:
  - state
  - cnt [cnt_nbits]
  - buf [nchunks*nbits_out]
- Reset: state=IDLE, cnt=0, buf=0. Output values during reset:
  - istream_rdy=1 once state is IDLE
  - ostream_val=0, ostream_last=0, busy=0
  - ostream_msg=0
- IDLE:
  - istream_rdy=1, ostream_val=0, busy=0.
  - On istream_val & istream_rdy: buf ← zero-extend(istream_msg) to nchunks*nbits_out, cnt ← 0, state ← SEND.
- SEND:
  - istream_rdy=0, ostream_val=1, busy=1.
  - ostream_msg = buf[(nchunks-1-cnt)*nbits_out +: nbits_out]: most-significant chunk first, the zero-padded chunk leads.
  - ostream_last = (cnt == nchunks-1).
  - On ostream_val & ostream_rdy:
    - If ostream_last: state ← IDLE, cnt ← 0.
    - Otherwise: cnt ← cnt+1.
  - With ostream_rdy=0 everything holds; ostream_val stays 1 and ostream_msg stays stable (no retraction).
- Latency:
  - First chunk is valid in the cycle after istream fires.
  - Minimum time per message is nchunks+1 cycles: nchunks sends plus one IDLE cycle.
- Gap guarantee: after the last chunk fires, ostream_val=0 for at least one cycle. istream_rdy is never asserted in SEND, so there is no bypass from last chunk to next load.
- nchunks==1: SEND lasts one fire; ostream_last=1 on that chunk.
- Outputs are purely functions of registered state; no combinational istream→ostream path.
- Reset mid-message: the partial message is dropped. The next cycle is IDLE with ostream_val=0, and no stale chunk is ever re-emitted.
- Simultaneous istream_val and reset: reset wins; the message is not captured.
- cnt never exceeds nchunks-1.

Test Plan:
- Single message, nbits_in=64, nbits_out=32, ostream_rdy=1, istream_msg=0x1122334455667788 -> cycle+1: ostream_msg=0x11223344, last=0; cycle+2: ostream_msg=0x55667788, last=1; cycle+3: ostream_val=0, istream_rdy=1.
- Backpressure: same message with ostream_rdy=0 for 3 cycles on chunk 0 -> ostream_val held at 1 and ostream_msg=0x11223344 stable throughout; chunk 1 follows only after ostream_rdy=1.
- Back-to-back: istream_val held high with 0xAAAAAAAA_BBBBBBBB then 0xCCCCCCCC_DDDDDDDD -> output sequence is AAAAAAAA, BBBBBBBB, one cycle of ostream_val=0, then CCCCCCCC, DDDDDDDD; istream_rdy=0 during SEND.
- Padding, nbits_in=40, nbits_out=16, msg=0xAB_CDEF_1234 -> three chunks 0x00AB, 0xCDEF, 0x1234; last=1 only on 0x1234.
- Reset mid-message: assert reset after chunk 0 fires -> next cycle ostream_val=0, busy=0, istream_rdy=1; a new message 0x0000000100000002 emits 0x00000001 then 0x00000002.
- Arbiter integration, two disassemblers with 2-chunk messages loaded in the same cycle -> input 0's two chunks emerge contiguously with addr 0, then input 1's two with addr 1; no interleaving.
